mii_frame_generator: RTL and testbench

MII_FRAME_GENERATOR -- requirements
Module: mii_frame_generator

---
 rtl/mii_frame_generator.sv | 153 +++++++++++++++
 tb/tb_mii_frame_generator.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mii_frame_generator.sv
// Frame generator: wraps payload words in start/terminate control words on a 64-bit
// MII lane interface and enforces the minimum inter-packet gap.
module mii_frame_generator #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CTRL_WIDTH = 8,
    parameter logic [7:0]  IDLE_CODE  = 8'h07,
    parameter logic [7:0]  START_CODE = 8'hFB,
    parameter logic [7:0]  TERM_CODE  = 8'hFD,
    parameter logic [7:0]  ERROR_CODE = 8'hFE,
    parameter int unsigned IPG_BYTES  = 12
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_last,
    input  logic [3:0]            i_last_bytes,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic [CTRL_WIDTH-1:0] o_tx_ctrl,
    output logic                  o_underrun,
    output logic [15:0]           o_frame_cnt
);
    localparam int Lanes = int'(CTRL_WIDTH);

    typedef enum logic [1:0] {StIdle, StData, StTerm, StDrop} state_e;

    state_e                state_q, state_d;
    logic [7:0]            ipg_q, ipg_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic [CTRL_WIDTH-1:0] tx_ctrl_q, tx_ctrl_d;
    logic                  underrun_q, underrun_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;

    logic [3:0]            last_n;
    logic [7:0]            ipg_inc;
    logic [DATA_WIDTH-1:0] idle_word, start_word, term_word, err_word, last_word;
    logic [CTRL_WIDTH-1:0] last_ctrl;

    assign last_n  = (i_last_bytes == 4'd0 || i_last_bytes > 4'(Lanes)) ? 4'(Lanes)
                                                                         : i_last_bytes;
    assign ipg_inc = (ipg_q > 8'd247) ? 8'd255 : ipg_q + 8'd8;
    assign o_ready = (state_q == StData) || (state_q == StDrop);

    // Fixed control words and the partially filled final word of a frame.
    always_comb begin
        idle_word  = '0;
        start_word = '0;
        last_word  = '0;
        last_ctrl  = '0;
        for (int i = 0; i < Lanes; i++) begin
            idle_word[8*i +: 8] = IDLE_CODE;
            if (i == 0) begin
                start_word[8*i +: 8] = START_CODE;
            end else if (i == Lanes - 1) begin
                start_word[8*i +: 8] = 8'hD5;
            end else begin
                start_word[8*i +: 8] = 8'h55;
            end
            if (i < int'(last_n)) begin
                last_word[8*i +: 8] = i_data[8*i +: 8];
            end else if (i == int'(last_n)) begin
                last_word[8*i +: 8] = TERM_CODE;
            end else begin
                last_word[8*i +: 8] = IDLE_CODE;
            end
            last_ctrl[i] = (i >= int'(last_n));
        end
        term_word        = idle_word;
        term_word[7:0]   = TERM_CODE;
        err_word         = idle_word;
        err_word[7:0]    = ERROR_CODE;
        err_word[15:8]   = TERM_CODE;
    end

    always_comb begin
        state_d     = state_q;
        ipg_d       = ipg_q;
        tx_data_d   = idle_word;
        tx_ctrl_d   = '1;
        underrun_d  = 1'b0;
        frame_cnt_d = frame_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (i_valid && ipg_q >= 8'(IPG_BYTES)) begin
                    tx_data_d = start_word;
                    tx_ctrl_d = CTRL_WIDTH'(1);
                    state_d   = StData;
                end else begin
                    ipg_d = ipg_inc;
                end
            end
            StData: begin
                if (!i_valid) begin
                    tx_data_d  = err_word;
                    underrun_d = 1'b1;
                    ipg_d      = 8'(Lanes - 2);
                    state_d    = StDrop;
                end else if (!i_last) begin
                    tx_data_d = i_data;
                    tx_ctrl_d = '0;
                end else if (last_n == 4'(Lanes)) begin
                    tx_data_d = i_data;
                    tx_ctrl_d = '0;
                    state_d   = StTerm;
                end else begin
                    tx_data_d   = last_word;
                    tx_ctrl_d   = last_ctrl;
                    ipg_d       = 8'(Lanes - 1) - 8'(last_n);
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = StIdle;
                end
            end
            StTerm: begin
                tx_data_d   = term_word;
                ipg_d       = 8'(Lanes - 1);
                frame_cnt_d = frame_cnt_q + 16'd1;
                state_d     = StIdle;
            end
            StDrop: begin
                ipg_d = ipg_inc;
                if (i_valid && i_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            ipg_q       <= 8'hFF;
            tx_data_q   <= idle_word;
            tx_ctrl_q   <= '1;
            underrun_q  <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            ipg_q       <= ipg_d;
            tx_data_q   <= tx_data_d;
            tx_ctrl_q   <= tx_ctrl_d;
            underrun_q  <= underrun_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign o_tx_data   = tx_data_q;
    assign o_tx_ctrl   = tx_ctrl_q;
    assign o_underrun  = underrun_q;
    assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_mii_frame_generator.sv
// Directed bench for mii_frame_generator: a vector table of per-cycle inputs and expected
// outputs, plus a hand sequence for the frame counter wrap.
module tb_mii_frame_generator;
    localparam logic [63:0] IdleW  = 64'h0707070707070707;
    localparam logic [63:0] StartW = 64'hD5555555555555FB;
    localparam logic [63:0] TermW  = 64'h07070707070707FD;
    localparam logic [63:0] ErrW   = 64'h070707070707FDFE;

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic [63:0] i_data = '0;
    logic        i_last = 1'b0;
    logic [3:0]  i_last_bytes = '0;
    logic        o_ready;
    logic [63:0] o_tx_data;
    logic [7:0]  o_tx_ctrl;
    logic        o_underrun;
    logic [15:0] o_frame_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst_n;
        logic        valid;
        logic        last;
        logic [3:0]  lb;
        logic [63:0] data;
        logic        exp_ready;
        logic [63:0] exp_data;
        logic [7:0]  exp_ctrl;
        logic        exp_und;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    mii_frame_generator dut (
        .clk          (clk),
        .i_rst_n      (i_rst_n),
        .i_valid      (i_valid),
        .i_data       (i_data),
        .i_last       (i_last),
        .i_last_bytes (i_last_bytes),
        .o_ready      (o_ready),
        .o_tx_data    (o_tx_data),
        .o_tx_ctrl    (o_tx_ctrl),
        .o_underrun   (o_underrun),
        .o_frame_cnt  (o_frame_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] dw(input int k);
        return (64'(k) * 64'h0101010101010101) ^ 64'hF0E1D2C3B4A59687;
    endfunction

    task automatic chk(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic rst_n, input logic valid, input logic last,
                       input logic [3:0] lb, input logic [63:0] data, input logic exp_ready,
                       input logic [63:0] exp_data, input logic [7:0] exp_ctrl,
                       input logic exp_und, input logic [15:0] exp_cnt);
        vec_t v;
        v.rst_n = rst_n; v.valid = valid; v.last = last; v.lb = lb; v.data = data;
        v.exp_ready = exp_ready; v.exp_data = exp_data; v.exp_ctrl = exp_ctrl;
        v.exp_und = exp_und; v.exp_cnt = exp_cnt;
        vecs.push_back(v);
    endtask

    task automatic step_chk(input int idx, input logic [63:0] exp_data,
                            input logic [7:0] exp_ctrl, input logic [15:0] exp_cnt);
        @(posedge clk);
        #1;
        chk("wrap_data", idx, o_tx_data, exp_data);
        chk("wrap_ctrl", idx, 64'(o_tx_ctrl), 64'(exp_ctrl));
        chk("wrap_cnt", idx, 64'(o_frame_cnt), 64'(exp_cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] d;

        // 64-byte frame, second frame queued behind it
        add(1, 1, 0, 0, dw(1), 0, StartW, 8'h01, 0, 0);
        for (int k = 1; k <= 8; k++) add(1, 1, k == 8, 8, dw(k), 1, dw(k), 8'h00, 0, 0);
        add(1, 1, 0, 0, dw(11), 0, TermW, 8'hFF, 0, 1);
        add(1, 1, 0, 0, dw(11), 0, IdleW, 8'hFF, 0, 1);
        add(1, 1, 0, 0, dw(11), 0, StartW, 8'h01, 0, 1);
        // 46-byte frame, last n=6
        for (int k = 11; k <= 15; k++) add(1, 1, 0, 0, dw(k), 1, dw(k), 8'h00, 0, 1);
        d = dw(16);
        add(1, 1, 1, 6, d, 1, {8'h07, 8'hFD, d[47:0]}, 8'hC0, 0, 2);
        add(1, 1, 0, 0, dw(20), 0, IdleW, 8'hFF, 0, 2);
        add(1, 1, 0, 0, dw(20), 0, IdleW, 8'hFF, 0, 2);
        add(1, 1, 0, 0, dw(20), 0, StartW, 8'h01, 0, 2);
        // last n=0 counts as 8
        add(1, 1, 1, 0, dw(20), 1, dw(20), 8'h00, 0, 2);
        add(1, 0, 0, 0, 64'd0, 0, TermW, 8'hFF, 0, 3);
        add(1, 1, 0, 0, dw(21), 0, IdleW, 8'hFF, 0, 3);
        add(1, 1, 0, 0, dw(21), 0, StartW, 8'h01, 0, 3);
        // underrun after 3 words, then drop through i_last
        for (int k = 21; k <= 23; k++) add(1, 1, 0, 0, dw(k), 1, dw(k), 8'h00, 0, 3);
        add(1, 0, 0, 0, 64'd0, 1, ErrW, 8'hFF, 1, 3);
        add(1, 1, 0, 0, dw(24), 1, IdleW, 8'hFF, 0, 3);
        add(1, 1, 1, 2, dw(25), 1, IdleW, 8'hFF, 0, 3);
        add(1, 1, 0, 0, dw(26), 0, StartW, 8'h01, 0, 3);
        // reset mid-frame, next frame starts at once
        add(1, 1, 0, 0, dw(26), 1, dw(26), 8'h00, 0, 3);
        add(1, 1, 0, 0, dw(27), 1, dw(27), 8'h00, 0, 3);
        add(0, 1, 0, 0, dw(28), 1, IdleW, 8'hFF, 0, 0);
        add(1, 1, 0, 0, dw(30), 0, StartW, 8'h01, 0, 0);
        d = dw(30);
        add(1, 1, 1, 3, d, 1, {32'h07070707, 8'hFD, d[23:0]}, 8'hF8, 0, 1);
        add(1, 0, 0, 0, 64'd0, 0, IdleW, 8'hFF, 0, 1);

        i_rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", 0, o_tx_data, IdleW);
        chk("rst_ctrl", 0, 64'(o_tx_ctrl), 64'hFF);
        chk("rst_und", 0, 64'(o_underrun), 64'd0);
        chk("rst_cnt", 0, 64'(o_frame_cnt), 64'd0);
        chk("rst_ready", 0, 64'(o_ready), 64'd0);

        for (int k = 0; k < vecs.size(); k++) begin
            i_rst_n      = vecs[k].rst_n;
            i_valid      = vecs[k].valid;
            i_last       = vecs[k].last;
            i_last_bytes = vecs[k].lb;
            i_data       = vecs[k].data;
            #1;
            chk("ready", k, 64'(o_ready), 64'(vecs[k].exp_ready));
            @(posedge clk);
            #1;
            chk("data", k, o_tx_data, vecs[k].exp_data);
            chk("ctrl", k, 64'(o_tx_ctrl), 64'(vecs[k].exp_ctrl));
            chk("underrun", k, 64'(o_underrun), 64'(vecs[k].exp_und));
            chk("frame_cnt", k, 64'(o_frame_cnt), 64'(vecs[k].exp_cnt));
        end

        // Counter wrap: preload near the top during an idle cycle, then run two frames.
        i_rst_n = 1'b1;
        i_valid = 1'b0;
        i_last  = 1'b0;
        force dut.frame_cnt_q = 16'hFFFE;
        step_chk(0, IdleW, 8'hFF, 16'hFFFE);
        release dut.frame_cnt_q;
        d            = dw(40);
        i_data       = d;
        i_valid      = 1'b1;
        i_last       = 1'b1;
        i_last_bytes = 4'd1;
        step_chk(1, StartW, 8'h01, 16'hFFFE);
        step_chk(2, {48'h070707070707, 8'hFD, d[7:0]}, 8'hFE, 16'hFFFF);
        i_data       = dw(41);
        i_last_bytes = 4'd9;
        step_chk(3, IdleW, 8'hFF, 16'hFFFF);
        step_chk(4, StartW, 8'h01, 16'hFFFF);
        step_chk(5, dw(41), 8'h00, 16'hFFFF);
        i_valid = 1'b0;
        i_last  = 1'b0;
        step_chk(6, TermW, 8'hFF, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
